// File: rtl/intensity_eval.sv
// intensity_eval
//   Avellaneda-Stoikov arrival intensities: lambda = A * exp(-k * delta) for the
//   bid and ask offsets. The block forms -k*delta and presents it to an external
//   exponential LUT, captures the LUT result, then scales it by A. A single LUT is
//   shared between the bid and ask sides by time-multiplexing.
//
// Ports
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_valid / o_ready           request handshake (accept on i_valid && o_ready)
//   i_delta_bid, i_delta_ask    signed q32.32 quote offsets
//   i_k                         signed q32.32 decay coefficient
//   i_a                         unsigned q32.32 base intensity
//   o_exp_arg                   signed q32.32 argument to the LUT (registered)
//   i_exp_value                 unsigned q32.32 LUT result, valid one cycle after
//                               o_exp_arg changes
//   o_valid / i_ready           result handshake
//   o_lambda_bid, o_lambda_ask  unsigned q32.32 intensities
module intensity_eval #(
  parameter int FRAC_BITS = 32,
  parameter int W         = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_delta_bid,
  input  logic [W-1:0] i_delta_ask,
  input  logic [W-1:0] i_k,
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_exp_arg,
  input  logic [W-1:0] i_exp_value,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_lambda_bid,
  output logic [W-1:0] o_lambda_ask
);

  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] U_MAX = {W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARG_BID = 3'd1,
    S_LUT_BID = 3'd2,
    S_LUT_ASK = 3'd3,
    S_SCALE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0] r_dbid, r_dask, r_k, r_a;
  logic [W-1:0] r_exp_bid, r_exp_ask;
  logic [W-1:0] r_exp_arg;
  logic [W-1:0] r_lam_bid, r_lam_ask;
  logic         r_valid;

  logic w_accept;

  assign o_ready      = (r_state == S_IDLE) && i_rst_n;
  assign w_accept     = i_valid && o_ready;
  assign o_exp_arg    = r_exp_arg;
  assign o_valid      = r_valid;
  assign o_lambda_bid = r_lam_bid;
  assign o_lambda_ask = r_lam_ask;

  // ---------------------------------------------------------------------------
  // argsat: -(k*delta) with saturation. One multiplier serves both sides; the
  // delta operand follows the state (bid in ARG_BID, ask in LUT_BID).
  // ---------------------------------------------------------------------------
  logic [W-1:0]          w_delta_sel;
  logic signed [2*W-1:0] w_k_ext, w_d_ext, w_prod, w_psh;
  logic                  w_povf;
  logic [W-1:0]          w_m, w_arg;

  assign w_delta_sel = (r_state == S_LUT_BID) ? r_dask : r_dbid;
  assign w_k_ext     = {{W{r_k[W-1]}}, r_k};
  assign w_d_ext     = {{W{w_delta_sel[W-1]}}, w_delta_sel};
  assign w_prod      = w_k_ext * w_d_ext;
  // Arithmetic shift drops the fraction, i.e. truncates toward -inf.
  assign w_psh       = w_prod >>> FRAC_BITS;
  // The shifted product fits in W signed bits only if everything from bit W-1
  // upward is a copy of the sign.
  assign w_povf      = !((&w_psh[2*W-1:W-1]) || !(|w_psh[2*W-1:W-1]));
  assign w_m         = w_povf ? (w_psh[2*W-1] ? S_MIN : S_MAX) : w_psh[W-1:0];
  // -MIN is not representable; clamp it to MAX.
  assign w_arg       = (w_m == S_MIN) ? S_MAX : (~w_m + 1'b1);

  // ---------------------------------------------------------------------------
  // lamsat: A*e unsigned, saturate when the integer part overflows W bits.
  // Both sides are scaled in the same cycle.
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] w_ubid, w_uask, w_ubid_sh, w_uask_sh;
  logic [W-1:0]   w_lam_bid, w_lam_ask;

  assign w_ubid    = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_exp_bid};
  assign w_uask    = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_exp_ask};
  assign w_ubid_sh = w_ubid >> FRAC_BITS;
  assign w_uask_sh = w_uask >> FRAC_BITS;
  assign w_lam_bid = (|w_ubid_sh[2*W-1:W]) ? U_MAX : w_ubid_sh[W-1:0];
  assign w_lam_ask = (|w_uask_sh[2*W-1:W]) ? U_MAX : w_uask_sh[W-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ARG_BID;
      S_ARG_BID: w_state_nxt = S_LUT_BID;
      S_LUT_BID: w_state_nxt = S_LUT_ASK;
      S_LUT_ASK: w_state_nxt = S_SCALE;
      S_SCALE:   w_state_nxt = S_DONE;
      S_DONE:    if (i_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dbid    <= '0;
      r_dask    <= '0;
      r_k       <= '0;
      r_a       <= '0;
      r_exp_bid <= '0;
      r_exp_ask <= '0;
      r_exp_arg <= '0;
      r_lam_bid <= '0;
      r_lam_ask <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dbid <= i_delta_bid;
            r_dask <= i_delta_ask;
            r_k    <= i_k;
            r_a    <= i_a;
          end
        end
        S_ARG_BID: r_exp_arg <= w_arg;
        // LUT result for the bid argument is ready now; switch LUT to ask.
        S_LUT_BID: begin
          r_exp_bid <= i_exp_value;
          r_exp_arg <= w_arg;
        end
        S_LUT_ASK: r_exp_ask <= i_exp_value;
        S_SCALE: begin
          r_lam_bid <= w_lam_bid;
          r_lam_ask <= w_lam_ask;
          r_valid   <= 1'b1;
        end
        S_DONE:  if (i_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intensity_eval.sv
module tb_intensity_eval;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, o_ready, o_valid, i_ready;
  logic [63:0] i_delta_bid, i_delta_ask, i_k, i_a, o_exp_arg, i_exp_value;
  logic [63:0] o_lambda_bid, o_lambda_ask;

  intensity_eval #(.FRAC_BITS(32), .W(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_delta_bid(i_delta_bid), .i_delta_ask(i_delta_ask),
    .i_k(i_k), .i_a(i_a),
    .o_exp_arg(o_exp_arg), .i_exp_value(i_exp_value),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_lambda_bid(o_lambda_bid), .o_lambda_ask(o_lambda_ask)
  );

  always #5 i_clk = ~i_clk;

  // LUT model: either a constant stub, or a small "real" table whose entry at
  // argument 0 is exp(0) = 1.0.
  logic        lut_real;
  logic [63:0] stub_val;
  always_comb begin
    if (lut_real) i_exp_value = (o_exp_arg == 64'd0) ? 64'h1_0000_0000 : 64'h0_5E2D_58D8;
    else          i_exp_value = stub_val;
  end

  typedef struct {
    logic [63:0] dbid, dask, k, a, stub;
    logic        real_lut;
    logic [63:0] arg_bid, arg_ask, lam_bid, lam_ask;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    i_delta_bid = v.dbid;
    i_delta_ask = v.dask;
    i_k         = v.k;
    i_a         = v.a;
    stub_val    = v.stub;
    lut_real    = v.real_lut;
  endtask

  // Full transaction with edge-exact checks; optionally completes the handshake.
  task automatic do_txn(input vec_t v, input bit hs, input string tag);
    drive(v);
    i_valid = 1'b1;
    chk({tag, " ready_before"}, {63'd0, o_ready}, 64'd1);
    tick();                                     // accept edge
    i_valid = 1'b0;
    chk({tag, " ready_busy"}, {63'd0, o_ready}, 64'd0);
    tick();                                     // e1
    chk({tag, " arg_bid"}, o_exp_arg, v.arg_bid);
    chk({tag, " valid_e1"}, {63'd0, o_valid}, 64'd0);
    tick();                                     // e2
    chk({tag, " arg_ask"}, o_exp_arg, v.arg_ask);
    tick();                                     // e3
    chk({tag, " valid_e3"}, {63'd0, o_valid}, 64'd0);
    chk({tag, " arg_hold_e3"}, o_exp_arg, v.arg_ask);
    tick();                                     // e4
    chk({tag, " valid_e4"}, {63'd0, o_valid}, 64'd1);
    chk({tag, " lam_bid"}, o_lambda_bid, v.lam_bid);
    chk({tag, " lam_ask"}, o_lambda_ask, v.lam_ask);
    chk({tag, " arg_hold_e4"}, o_exp_arg, v.arg_ask);
    if (hs) begin
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk({tag, " valid_drop"}, {63'd0, o_valid}, 64'd0);
      chk({tag, " ready_after"}, {63'd0, o_ready}, 64'd1);
      chk({tag, " lam_bid_kept"}, o_lambda_bid, v.lam_bid);
    end
  endtask

  initial begin
    //           dbid                    dask                    k                       a                       stub                 real  arg_bid                 arg_ask                 lam_bid                 lam_ask
    vecs[0] = '{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 64'h0000_0000_8000_0000, 1'b0,
                64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000};
    vecs[1] = '{64'h0, 64'h0, 64'h0000_0001_0000_0000, 64'h0000_0003_4000_0000, 64'h0, 1'b1,
                64'h0, 64'h0, 64'h0000_0003_4000_0000, 64'h0000_0003_4000_0000};
    vecs[2] = '{64'h0000_7FFF_0000_0000, 64'h0000_7FFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0004_0000_0000, 1'b0,
                64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    // -1 LSB product truncates to -1 -> +1; +1 LSB product truncates to 0.
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 64'h0000_0001_8000_0000, 1'b0,
                64'h0000_0000_0000_0001, 64'h0, 64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000};
    // m == MIN exactly without overflow; largest non-saturating lambda.
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{64'h0000_0004_0000_0000, 64'hFFFF_FFF8_0000_0000, 64'h0000_0000_4000_0000, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 1'b0,
                64'hFFFF_FFFF_0000_0000, 64'h0000_0002_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    // Negative and positive overflow of k*delta.
    vecs[6] = '{64'h0000_7FFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h0000_0002_0000_0000, 64'h0000_0002_0000_0000};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    drive(vecs[0]);

    // Reset state
    tick(); tick();
    chk("rst ready_low", {63'd0, o_ready}, 64'd0);
    chk("rst valid", {63'd0, o_valid}, 64'd0);
    chk("rst exp_arg", o_exp_arg, 64'd0);
    chk("rst lam_bid", o_lambda_bid, 64'd0);
    chk("rst lam_ask", o_lambda_ask, 64'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst ready_high", {63'd0, o_ready}, 64'd1);

    for (int i = 0; i < 7; i++) do_txn(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Backpressure in DONE with new data offered
    do_txn(vecs[0], 1'b0, "bp");
    drive(vecs[6]);
    i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp valid_held", {63'd0, o_valid}, 64'd1);
      chk("bp ready_low", {63'd0, o_ready}, 64'd0);
      chk("bp lam_bid_held", o_lambda_bid, vecs[0].lam_bid);
      chk("bp lam_ask_held", o_lambda_ask, vecs[0].lam_ask);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp valid_drop", {63'd0, o_valid}, 64'd0);
    chk("bp ready_back", {63'd0, o_ready}, 64'd1);
    do_txn(vecs[2], 1'b1, "bp_next");

    // Reset pulse while in LUT_ASK
    drive(vecs[3]);
    i_valid = 1'b1;
    tick();                 // accept
    i_valid = 1'b0;
    tick();                 // -> LUT_BID
    tick();                 // -> LUT_ASK
    i_rst_n = 1'b0;
    tick();
    chk("rp exp_arg", o_exp_arg, 64'd0);
    chk("rp lam_bid", o_lambda_bid, 64'd0);
    chk("rp lam_ask", o_lambda_ask, 64'd0);
    chk("rp valid", {63'd0, o_valid}, 64'd0);
    chk("rp ready_low", {63'd0, o_ready}, 64'd0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rp no_valid", {63'd0, o_valid}, 64'd0);
    end
    do_txn(vecs[5], 1'b1, "rp_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
